// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first. A full-subtractor cell and a borrow flip-flop do the arithmetic.
// A three-state FSM (IDLE -> SHIFT -> DONE) runs the start/busy/done handshake.
//
// Optional feature (compile-time macro SERIAL_SUB_ZFLAG_EN):
//   adds a 'zero' output. It is computed serially by OR-accumulating every
//   difference bit as it is produced, so no WIDTH-wide compare is needed.
//
// Latency : start accepted at edge N -> busy in cycles N+1..N+WIDTH,
//           done in cycle N+WIDTH+1.
// Reset   : synchronous, active-low.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 32          // operand width, legal range 2..64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  // Counter wide enough to index WIDTH-1 bits.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  // Operand shift registers. Both are consumed from bit 0.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  // The result is assembled from the MSB end, so after WIDTH shifts each
  // difference bit sits at its own index.
  logic [WIDTH-1:0] res;

  logic             borrow;
  logic [CW-1:0]    count;
  logic             a_msb;
  logic             b_msb;

`ifdef SERIAL_SUB_ZFLAG_EN
  logic             zacc;           // OR of all difference bits so far
`endif

  // Full-subtractor cell operands for the current bit.
  logic x, y, d, borrow_next, last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell: difference and borrow for the current bit.
  always_comb begin
    x           = a_sh[0];
    y           = b_sh[0];
    d           = x ^ y ^ borrow;
    borrow_next = (~x & y) | (~x & borrow) | (y & borrow);
    res_next    = {d, res[WIDTH-1:1]};
    last_bit    = (count == CW'(WIDTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values; blocking here would create order-dependent races.
      state <= state_next;
    end
  end

  // FSM next-state and the handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;          // start is ignored in DONE
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial subtraction, result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      borrow   <= 1'b0;
      count    <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
`ifdef SERIAL_SUB_ZFLAG_EN
      zacc     <= 1'b0;
      zero     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // Published results hold until a new operation is accepted.
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            borrow <= 1'b0;
            count  <= '0;
`ifdef SERIAL_SUB_ZFLAG_EN
            zacc   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res    <= res_next;
          borrow <= borrow_next;
          count  <= count + CW'(1);
`ifdef SERIAL_SUB_ZFLAG_EN
          zacc   <= zacc | d;
`endif
          // On the last bit, register the finished result so it is visible
          // in the DONE cycle and stays stable afterwards.
          if (last_bit) begin
            diff     <= res_next;
            bout     <= borrow_next;
            overflow <= (a_msb != b_msb) && (d != a_msb);
`ifdef SERIAL_SUB_ZFLAG_EN
            zero     <= ~(zacc | d);
`endif
          end
        end
        default: ;                  // DONE: results already published
      endcase
    end
  end

endmodule
